// File: rtl/spi_coeff_loader.sv
// SPI slave that assembles 32-bit MSB-first packets and turns each one into a FIR coefficient-bank write.
// Optional build macro MISO_ECHO_EN: MISO echoes the previous packet during the next frame.
module spi_coeff_loader #(
    parameter int unsigned   NUM_TAPS  = 32,
    parameter int unsigned   COEFF_W   = 12,
    parameter logic [7:0]    HDR_WRITE = 8'hFB,
    localparam int unsigned  ADDR_W    = 5
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               SCK,
    input  logic               CS,
    input  logic               MOSI,
    output logic               MISO,
    output logic               coeff_we,
    output logic [ADDR_W-1:0]  coeff_addr,
    output logic [COEFF_W-1:0] coeff_data,
    output logic               cfg_done,
    output logic               frame_err,
    output logic [7:0]         err_count
);

    localparam int unsigned PKT_W = 32;
    localparam int unsigned CNT_W = 6;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SHIFT   = 2'd1,
        DECODE  = 2'd2,
        WAIT_CS = 2'd3
    } state_t;

    state_t state, state_next;

    logic [2:0]          sck_sr;
    logic [1:0]          cs_sr;
    logic [1:0]          mosi_sr;
    logic                sck_s, sck_d, cs_s, mosi_s;
    logic                fall_r;
    logic                armed;
    logic [PKT_W-1:0]    shreg;
    logic [CNT_W-1:0]    bitcnt;
    logic [NUM_TAPS-1:0] mask;

    logic shift_en_c, clr_cnt_c, dec_c, frame_err_c;
    logic pkt_valid_c, we_c, err_inc_c;
    logic unused_pad_bits;

    assign sck_s  = sck_sr[1];
    assign sck_d  = sck_sr[2];
    assign cs_s   = cs_sr[1];
    assign mosi_s = mosi_sr[1];

    // Two-flop synchronisers plus a registered fall strobe; coeff_we lands 4 Clk after the first sync flop sees the fall
    always_ff @(posedge Clk) begin
        if (Reset) begin
            sck_sr  <= '0;
            cs_sr   <= '0;
            mosi_sr <= '0;
            fall_r  <= 1'b0;
        end else begin
            sck_sr  <= {sck_sr[1:0], SCK};
            cs_sr   <= {cs_sr[0], CS};
            mosi_sr <= {mosi_sr[0], MOSI};
            fall_r  <= sck_d & ~sck_s;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        shift_en_c  = 1'b0;
        clr_cnt_c   = 1'b0;
        dec_c       = 1'b0;
        frame_err_c = 1'b0;
        case (state)
            IDLE: begin
                // armed keeps a frame interrupted by Reset from being picked up mid-stream
                if (armed && !cs_s) begin
                    state_next = SHIFT;
                    clr_cnt_c  = 1'b1;
                end
            end
            SHIFT: begin
                if (fall_r) begin
                    shift_en_c = 1'b1;
                    if (bitcnt == CNT_W'(PKT_W - 1)) begin
                        state_next = DECODE;
                    end
                end else if (cs_s) begin
                    frame_err_c = 1'b1;
                    state_next  = IDLE;
                end
            end
            DECODE: begin
                dec_c      = 1'b1;
                state_next = WAIT_CS;
            end
            WAIT_CS: begin
                if (cs_s) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign pkt_valid_c     = (shreg[31:24] == HDR_WRITE) && (32'(shreg[23:16]) < NUM_TAPS);
    assign we_c            = dec_c & pkt_valid_c;
    assign err_inc_c       = frame_err_c | (dec_c & ~pkt_valid_c);
    assign unused_pad_bits = ^shreg[15:COEFF_W];

    always_ff @(posedge Clk) begin
        if (Reset) begin
            armed      <= 1'b0;
            shreg      <= '0;
            bitcnt     <= '0;
            mask       <= '0;
            coeff_we   <= 1'b0;
            coeff_addr <= '0;
            coeff_data <= '0;
            cfg_done   <= 1'b0;
            frame_err  <= 1'b0;
            err_count  <= '0;
        end else begin
            if (cs_s) begin
                armed <= 1'b1;
            end
            if (clr_cnt_c) begin
                bitcnt <= '0;
            end else if (shift_en_c) begin
                shreg  <= {shreg[PKT_W-2:0], mosi_s};
                bitcnt <= bitcnt + CNT_W'(1);
            end
            coeff_we  <= we_c;
            frame_err <= frame_err_c;
            if (we_c) begin
                coeff_addr                   <= shreg[16 +: ADDR_W];
                coeff_data                   <= shreg[COEFF_W-1:0];
                mask[shreg[16 +: ADDR_W]]    <= 1'b1;
            end
            cfg_done <= &mask;
            if (err_inc_c && (err_count != 8'hFF)) begin
                err_count <= err_count + 8'd1;
            end
        end
    end

`ifdef MISO_ECHO_EN
    logic [PKT_W-1:0] echo;
    logic [4:0]       miso_idx;
    logic             rise_r;

    // Echo of the last completed packet, shifted out one bit per SCK rise during the next frame
    always_ff @(posedge Clk) begin
        if (Reset) begin
            echo     <= '0;
            miso_idx <= '0;
            rise_r   <= 1'b0;
            MISO     <= 1'b0;
        end else begin
            rise_r <= ~sck_d & sck_s;
            if (dec_c) begin
                echo <= shreg;
            end
            if (clr_cnt_c) begin
                miso_idx <= 5'd31;
                MISO     <= 1'b0;
            end else if ((state == SHIFT) && rise_r) begin
                MISO     <= echo[miso_idx];
                miso_idx <= miso_idx - 5'd1;
            end else if (cs_s) begin
                MISO <= 1'b0;
            end
        end
    end
`else
    assign MISO = 1'b0;
`endif

endmodule

// File: tb/tb_spi_coeff_loader.sv
// Directed bench for spi_coeff_loader: drives SPI frames (MOSI changes on SCK rise) and checks strobes, errors and MISO.
module tb_spi_coeff_loader;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        SCK, CS, MOSI;
    logic        MISO;
    logic        coeff_we;
    logic [4:0]  coeff_addr;
    logic [11:0] coeff_data;
    logic        cfg_done;
    logic        frame_err;
    logic [7:0]  err_count;

    int errors = 0;
    int checks = 0;

    int          we_cnt = 0;
    int          we_long = 0;
    int          fe_cnt = 0;
    logic        we_prev = 1'b0;
    logic [4:0]  last_addr = '0;
    logic [11:0] last_data = '0;
    logic [11:0] bank [32];
    logic [31:0] miso_word;
    logic [31:0] exp_echo;

    spi_coeff_loader dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .SCK        (SCK),
        .CS         (CS),
        .MOSI       (MOSI),
        .MISO       (MISO),
        .coeff_we   (coeff_we),
        .coeff_addr (coeff_addr),
        .coeff_data (coeff_data),
        .cfg_done   (cfg_done),
        .frame_err  (frame_err),
        .err_count  (err_count)
    );

    always #5 Clk = ~Clk;

    // Strobe monitor; also flags any coeff_we wider than one Clk
    always @(negedge Clk) begin
        if (coeff_we) begin
            we_cnt++;
            last_addr = coeff_addr;
            last_data = coeff_data;
            bank[coeff_addr] = coeff_data;
            if (we_prev) we_long++;
        end
        we_prev = coeff_we;
        if (frame_err) fe_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".we"},   32'(coeff_we),   32'd0);
        check({tag, ".addr"}, 32'(coeff_addr), 32'd0);
        check({tag, ".data"}, 32'(coeff_data), 32'd0);
        check({tag, ".done"}, 32'(cfg_done),   32'd0);
        check({tag, ".ferr"}, 32'(frame_err),  32'd0);
        check({tag, ".errc"}, 32'(err_count),  32'd0);
        check({tag, ".miso"}, 32'(MISO),       32'd0);
    endtask

    // One frame of nbits; rst_bit >= 0 pulses Reset for 2 Clk just before that bit
    task automatic send_frame(input logic [31:0] w, input int nbits, input int rst_bit);
        miso_word = '0;
        CS = 1'b0;
        repeat (8) @(posedge Clk);
        for (int i = 0; i < nbits; i++) begin
            if (i == rst_bit) begin
                @(negedge Clk);
                Reset = 1'b1;
                repeat (2) @(negedge Clk);
                check_reset_outputs("midrst");
                Reset = 1'b0;
            end
            SCK  = 1'b1;
            MOSI = w[31-i];
            repeat (8) @(posedge Clk);
            #1 miso_word[31-i] = MISO;
            SCK = 1'b0;
            repeat (8) @(posedge Clk);
        end
        repeat (8) @(posedge Clk);
        CS = 1'b1;
        repeat (10) @(posedge Clk);
        #1;
    endtask

    initial begin
        int base_we;
        Reset = 1'b1;
        SCK   = 1'b0;
        CS    = 1'b1;
        MOSI  = 1'b0;
        for (int i = 0; i < 32; i++) bank[i] = '0;
        repeat (3) @(posedge Clk);
        #1 check_reset_outputs("reset");
        Reset = 1'b0;
        repeat (4) @(posedge Clk);

        // Single good write
        send_frame(32'hFB03_0ABC, 32, -1);
        check("t1.we_cnt", 32'(we_cnt), 32'd1);
        check("t1.addr", 32'(last_addr), 32'd3);
        check("t1.data", 32'(last_data), 32'hABC);
        check("t1.errc", 32'(err_count), 32'd0);
        check("t1.miso", miso_word, 32'h0);

        // Fill every tap with its own index
        for (int i = 0; i < 32; i++) begin
            send_frame({8'hFB, 8'(i), 16'(i)}, 32, -1);
            if (i == 30) check("t2.done_early", 32'(cfg_done), 32'd0);
        end
        check("t2.done", 32'(cfg_done), 32'd1);
        check("t2.we_cnt", 32'(we_cnt), 32'd33);
        for (int i = 0; i < 32; i++) check($sformatf("t2.bank%0d", i), 32'(bank[i]), 32'(i));

        // Bad header, then out-of-range index
        send_frame(32'hA503_0123, 32, -1);
        send_frame(32'hFB40_0001, 32, -1);
        check("t3.we_cnt", 32'(we_cnt), 32'd33);
        check("t3.errc", 32'(err_count), 32'd2);
        check("t3.fe_cnt", 32'(fe_cnt), 32'd0);

        // Short frame then a good one
        send_frame(32'hFB09_0777, 20, -1);
        check("t4.fe_cnt", 32'(fe_cnt), 32'd1);
        check("t4.errc", 32'(err_count), 32'd3);
        check("t4.we_cnt", 32'(we_cnt), 32'd33);
        send_frame(32'hFB05_0FFF, 32, -1);
        check("t4.addr", 32'(last_addr), 32'd5);
        check("t4.data", 32'(last_data), 32'hFFF);
        check("t4.we_cnt2", 32'(we_cnt), 32'd34);
        check("t4.done", 32'(cfg_done), 32'd1);

        // Reset in the middle of a frame
        base_we = we_cnt;
        send_frame(32'hFB07_0123, 32, 16);
        check("t5.no_we", 32'(we_cnt), 32'(base_we));
        check("t5.errc", 32'(err_count), 32'd0);
        check("t5.fe_cnt", 32'(fe_cnt), 32'd1);
        check("t5.done", 32'(cfg_done), 32'd0);
        send_frame(32'hFB07_0123, 32, -1);
        check("t5.we_cnt", 32'(we_cnt), 32'(base_we + 1));
        check("t5.addr", 32'(last_addr), 32'd7);
        check("t5.data", 32'(last_data), 32'h123);

        // Echo of the previous packet on MISO
        send_frame(32'hFB01_0555, 32, -1);
`ifdef MISO_ECHO_EN
        exp_echo = 32'hFB07_0123;
`else
        exp_echo = 32'h0;
`endif
        check("t6.echo1", miso_word, exp_echo);
        send_frame(32'hFB02_0AAA, 32, -1);
`ifdef MISO_ECHO_EN
        exp_echo = 32'hFB01_0555;
`else
        exp_echo = 32'h0;
`endif
        check("t6.echo2", miso_word, exp_echo);
        check("t6.miso_idle", 32'(MISO), 32'd0);
        check("t6.addr", 32'(last_addr), 32'd2);
        check("t6.data", 32'(last_data), 32'hAAA);
        check("we_width", 32'(we_long), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
